pam4_chain_sequencer: RTL and testbench

//   Run/flush controller for the PAM4 up-sample / TX / RX / down-sample chain.
//   - Generates the clock-phase counter, sample strobe (smp_en) and symbol strobe (sym_en).
//   - Maps 2 LFSR bits per sample to a signed 18-bit PAM4 level.
//   - Sequences IDLE -> RUN -> FLUSH and flags when chain output is valid.

---
 rtl/pam4_chain_sequencer_pkg.sv | 32 +++
 rtl/pam4_chain_sequencer_strobe_gen.sv | 34 +++
 rtl/pam4_chain_sequencer.sv | 144 ++++++++++++++
 tb/tb_pam4_chain_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pam4_chain_sequencer_pkg.sv
// Shared types and constants for the PAM4 chain run/flush sequencer.
// Holds the FSM state encoding, sample/phase widths and the PAM4 level table.
package pam4_chain_pkg;

    localparam int SMP_W   = 18;
    localparam int PHASE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Full-scale 18-bit signed PAM4 levels (two's complement hex).
    localparam logic signed [SMP_W-1:0] LVL_M3 = 18'sh20000;  // -131072
    localparam logic signed [SMP_W-1:0] LVL_M1 = 18'sh35555;  // -43691
    localparam logic signed [SMP_W-1:0] LVL_P1 = 18'sh0AAAA;  // +43690
    localparam logic signed [SMP_W-1:0] LVL_P3 = 18'sh1FFFF;  // +131071

    // Two LFSR bits to one PAM4 level (binary order, not Gray).
    function automatic logic signed [SMP_W-1:0] pam4_map(input logic [1:0] bits);
        logic signed [SMP_W-1:0] lvl;
        case (bits)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b10:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/pam4_chain_sequencer_strobe_gen.sv
// chain_strobe_gen: free-running clock-phase counter with sample/symbol strobe decode.
// The counter only advances while run is high; clr forces it back to zero on the next edge.
module chain_strobe_gen
    import pam4_chain_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               clr,
    output logic [PHASE_W-1:0] phase,
    output logic               smp_en,
    output logic               sym_en
);

    logic [PHASE_W-1:0] phase_reg;

    // Phase counter: held at zero when idle or cleared, otherwise wraps 15 -> 0.
    always_ff @(posedge clk) begin
        if (reset || clr || !run) begin
            phase_reg <= '0;
        end else begin
            phase_reg <= phase_reg + 1'b1;
        end
    end

    // Strobes decode straight from the registered phase so they line up with it.
    always_comb begin
        smp_en = run && (phase_reg[1:0] == 2'b11);
        sym_en = run && (&phase_reg);
    end

    assign phase = phase_reg;

endmodule

// File: rtl/pam4_chain_sequencer.sv
// pam4_chain_sequencer: IDLE -> RUN -> FLUSH controller for the PAM4 chain.
// Drives the up-sampler with mapped PAM4 levels, then zeros to drain the filters.
// Optional feature: define SYM_CNT_EN to build the RUN sample counter on sym_count.
module pam4_chain_sequencer
    import pam4_chain_pkg::*;
#(
    parameter int LAT_SMP   = 24,
    parameter int FLUSH_SMP = 32,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              lfsr_bits,
    output logic [PHASE_W-1:0]      phase,
    output logic                    smp_en,
    output logic                    sym_en,
    output logic signed [SMP_W-1:0] x_sym,
    output logic                    busy,
    output logic                    out_valid,
    output logic                    done,
    output logic [15:0]             sym_count
);

    localparam logic [CNT_W-1:0] LAT_FULL   = CNT_W'(LAT_SMP);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(LAT_SMP - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_SMP - 1);

    state_t                  state_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic signed [SMP_W-1:0] x_sym_reg;
    logic                    busy_reg;
    logic                    out_valid_reg;
    logic                    done_reg;

    logic start_acc;
    logic flush_last;
    logic strobe_clr;
    logic smp_en_w;
    logic sym_en_w;

    // Accepted start and the final flush strobe both restart the phase from zero.
    always_comb begin
        start_acc  = (state_reg == IDLE) && start;
        flush_last = (state_reg == FLUSH) && smp_en_w && (cnt_reg == FLUSH_LAST);
        strobe_clr = start_acc || flush_last;
    end

    chain_strobe_gen u_strobe (
        .clk    (clk),
        .reset  (reset),
        .run    (busy_reg),
        .clr    (strobe_clr),
        .phase  (phase),
        .smp_en (smp_en_w),
        .sym_en (sym_en_w)
    );

    // Run/flush FSM with the PAM4 mapper and the latency/flush strobe counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            x_sym_reg     <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    if (smp_en_w) begin
                        x_sym_reg <= pam4_map(lfsr_bits);
                        // Counter saturates once the chain latency has been covered.
                        if (cnt_reg != LAT_FULL) begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                        if (cnt_reg == LAT_LAST) begin
                            out_valid_reg <= 1'b1;
                        end
                    end
                    // Phase keeps running into FLUSH so strobe cadence is unbroken.
                    if (stop) begin
                        state_reg <= FLUSH;
                        cnt_reg   <= '0;
                    end
                end
                FLUSH: begin
                    if (smp_en_w) begin
                        x_sym_reg <= '0;
                        if (cnt_reg == FLUSH_LAST) begin
                            state_reg     <= IDLE;
                            cnt_reg       <= '0;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SYM_CNT_EN
    logic [15:0] sym_count_reg;

    // Samples issued during RUN; cleared by an accepted start, held elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_count_reg <= 16'd0;
        end else if (start_acc) begin
            sym_count_reg <= 16'd0;
        end else if ((state_reg == RUN) && smp_en_w) begin
            sym_count_reg <= sym_count_reg + 16'd1;
        end
    end

    assign sym_count = sym_count_reg;
`else
    assign sym_count = 16'd0;
`endif

    assign smp_en    = smp_en_w;
    assign sym_en    = sym_en_w;
    assign x_sym     = x_sym_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_pam4_chain_sequencer.sv
// Directed bench for pam4_chain_sequencer: cycle-level reference model plus an
// x_sym scoreboard (expected level queued at each strobe, popped the next cycle).
module tb_pam4_chain_sequencer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic [1:0]         lfsr_bits;
    logic [3:0]         phase;
    logic               smp_en;
    logic               sym_en;
    logic signed [17:0] x_sym;
    logic               busy;
    logic               out_valid;
    logic               done;
    logic [15:0]        sym_count;

    pam4_chain_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .lfsr_bits (lfsr_bits),
        .phase     (phase),
        .smp_en    (smp_en),
        .sym_en    (sym_en),
        .x_sym     (x_sym),
        .busy      (busy),
        .out_valid (out_valid),
        .done      (done),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state. since = cycles elapsed since the accepted start.
    int                 m_mode = 0;   // 0 idle, 1 run, 2 flush
    int                 since  = 0;
    int                 m_strb = 0;
    int                 m_sc   = 0;
    bit                 m_busy = 0;
    bit                 m_valid = 0;
    bit                 m_done = 0;
    logic signed [17:0] m_x = '0;
    logic signed [17:0] xq[$];

    int n_fl;
    int n_done;
    int valid_rise;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic signed [17:0] lvl(input logic [1:0] b);
        int v;
        case (b)
            2'b00:   v = -131072;
            2'b01:   v = -43691;
            2'b10:   v = 43690;
            default: v = 131071;
        endcase
        return v[17:0];
    endfunction

    // Apply the currently driven inputs for one clock, advance the model, check all outputs.
    task automatic tick();
        bit   smp_now;
        bit   pushed;
        logic [15:0] exp_sc;
        smp_now = m_busy && (since > 0) && (since % 4 == 0);
        pushed  = 0;
        m_done  = 0;
        if (reset) begin
            m_mode = 0; m_busy = 0; m_valid = 0; m_strb = 0; m_sc = 0; m_x = '0;
            xq.delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_busy = 1; m_strb = 0; m_sc = 0;
                end
                1: begin
                    if (smp_now) begin
                        xq.push_back(lvl(lfsr_bits));
                        pushed = 1;
                        m_sc = (m_sc + 1) % 65536;
                        if (m_strb < 24) begin
                            m_strb++;
                            if (m_strb == 24) m_valid = 1;
                        end
                    end
                    if (stop) begin
                        m_mode = 2; m_strb = 0;
                    end
                end
                default: if (smp_now) begin
                    xq.push_back('0);
                    pushed = 1;
                    m_strb++;
                    if (m_strb == 32) begin
                        m_mode = 0; m_busy = 0; m_valid = 0; m_done = 1;
                    end
                end
            endcase
        end
        since = m_busy ? since + 1 : 0;

        @(posedge clk);
        #1;

`ifdef SYM_CNT_EN
        exp_sc = 16'(m_sc);
`else
        exp_sc = 16'd0;
`endif
        chk("busy",      32'(busy),      32'(m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("done",      32'(done),      32'(m_done));
        chk("phase",     32'(phase),     m_busy ? 32'((since - 1) % 16) : 32'd0);
        chk("smp_en",    32'(smp_en),    32'(m_busy && (since % 4 == 0)));
        chk("sym_en",    32'(sym_en),    32'(m_busy && (since % 16 == 0)));
        if (pushed) begin
            m_x = xq.pop_front();
            $display("strobe since=%0d mode=%0d x_sym=%0d exp=%0d", since, m_mode, x_sym, m_x);
        end
        chk("x_sym",     32'(x_sym),     32'(m_x));
        chk("sym_count", 32'(sym_count), 32'(exp_sc));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; lfsr_bits = 2'b00;

        // Reset, then idle with a stray stop: phase must stay at zero.
        repeat (3) tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            stop = (k == 7);
            tick();
        end
        stop = 1'b0;

        // Long RUN with the 00,01,10,11 pattern on successive strobes; start mid-run ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        valid_rise = -1;
        for (int k = 0; k < 109; k++) begin
            lfsr_bits = 2'((since / 4 + 3) % 4);
            start     = (since == 50);
            tick();
            if (out_valid === 1'b1 && valid_rise < 0) valid_rise = since;
            if (since == 5)  chk("map_00", 32'(x_sym), -131072);
            if (since == 9)  chk("map_01", 32'(x_sym), -43691);
            if (since == 13) chk("map_10", 32'(x_sym), 43690);
            if (since == 17) chk("map_11", 32'(x_sym), 131071);
        end
        start = 1'b0;
        chk("valid_rise_cycle", 32'(valid_rise), 32'd97);

        // Stop, then FLUSH with start/stop pokes that must be ignored.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_fl = 0; n_done = 0;
        for (int k = 0; k < 200 && m_mode == 2; k++) begin
            start = (k == 20);
            stop  = (k == 30);
            lfsr_bits = 2'($urandom_range(0, 3));
            if (smp_en === 1'b1) n_fl++;
            tick();
            if (done === 1'b1) n_done++;
        end
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("flush_strobes", 32'(n_fl), 32'd32);
        chk("done_pulses", 32'(n_done), 32'd1);

        // start+stop together in IDLE enters RUN; stop early after 10 strobes.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 40; k++) begin
            lfsr_bits = 2'($urandom_range(0, 3));
            tick();
        end
`ifdef SYM_CNT_EN
        chk("sym_count_10", 32'(sym_count), 32'd10);
`else
        chk("sym_count_tied", 32'(sym_count), 32'd0);
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_done = 0;
        for (int k = 0; k < 200 && m_mode == 2; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("early_stop_done", 32'(n_done), 32'd1);
`ifdef SYM_CNT_EN
        chk("sym_count_hold", 32'(sym_count), 32'd10);
`endif

        // Reset mid-RUN aborts without a done pulse.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            lfsr_bits = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x_sym", 32'(x_sym), 32'd0);
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("rst_no_done", 32'(n_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
